// File: rtl/ctr_step_sched.sv
// Round-robin scheduler that shares an up/down step counter datapath between an
// increment and a decrement requester, keeping a shadow count to refuse out-of-range steps.
module ctr_step_sched #(
    parameter int unsigned MAXV = 20,
    parameter int unsigned W    = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_req,
    output logic         up_ack,
    output logic         up_nak,
    input  logic         dn_req,
    output logic         dn_ack,
    output logic         dn_nak,
    input  logic         clr,
    output logic         ct,
    output logic         cn,
    output logic         ctr_rst,
    output logic [W-1:0] level,
    output logic         full,
    output logic         empty
);

    localparam logic [W-1:0] MAX_LVL = W'(MAXV);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        REFUSE,
        CLEAR,
        RELEASE
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] level_q, level_d;
    logic         rr_q, rr_d;
    logic         sel_dn_q, sel_dn_d;
    logic         clr_pend_q, clr_pend_d;
    logic         ct_q, ct_d;
    logic         cn_q, cn_d;
    logic         ctr_rst_q, ctr_rst_d;
    logic         up_ack_q, up_ack_d;
    logic         up_nak_q, up_nak_d;
    logic         dn_ack_q, dn_ack_d;
    logic         dn_nak_q, dn_nak_d;

    // rr_q = 1 gives the decrement side priority when both requests are high
    logic pick_dn_c;
    logic legal_c;
    logic served_req_c;

    assign pick_dn_c    = dn_req & (~up_req | rr_q);
    assign legal_c      = pick_dn_c ? (level_q != '0) : (level_q < MAX_LVL);
    assign served_req_c = sel_dn_q ? dn_req : up_req;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            level_q    <= '0;
            rr_q       <= 1'b0;
            sel_dn_q   <= 1'b0;
            clr_pend_q <= 1'b0;
            ct_q       <= 1'b0;
            cn_q       <= 1'b0;
            ctr_rst_q  <= 1'b1;
            up_ack_q   <= 1'b0;
            up_nak_q   <= 1'b0;
            dn_ack_q   <= 1'b0;
            dn_nak_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            rr_q       <= rr_d;
            sel_dn_q   <= sel_dn_d;
            clr_pend_q <= clr_pend_d;
            ct_q       <= ct_d;
            cn_q       <= cn_d;
            ctr_rst_q  <= ctr_rst_d;
            up_ack_q   <= up_ack_d;
            up_nak_q   <= up_nak_d;
            dn_ack_q   <= dn_ack_d;
            dn_nak_q   <= dn_nak_d;
        end
    end

    // Next state; output pulses are computed one cycle ahead so they align with the state
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        rr_d       = rr_q;
        sel_dn_d   = sel_dn_q;
        clr_pend_d = clr_pend_q | clr;
        ct_d       = 1'b0;
        cn_d       = 1'b0;
        ctr_rst_d  = 1'b1;
        up_ack_d   = 1'b0;
        up_nak_d   = 1'b0;
        dn_ack_d   = 1'b0;
        dn_nak_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr_pend_q || clr) begin
                    state_d    = CLEAR;
                    ctr_rst_d  = 1'b0;
                    clr_pend_d = 1'b0;
                end else if (up_req || dn_req) begin
                    sel_dn_d = pick_dn_c;
                    rr_d     = ~pick_dn_c;
                    if (legal_c) begin
                        state_d  = ISSUE;
                        cn_d     = 1'b1;
                        ct_d     = pick_dn_c;
                        up_ack_d = ~pick_dn_c;
                        dn_ack_d = pick_dn_c;
                    end else begin
                        state_d  = REFUSE;
                        up_nak_d = ~pick_dn_c;
                        dn_nak_d = pick_dn_c;
                    end
                end
            end
            ISSUE: begin
                level_d = sel_dn_q ? (level_q - W'(1)) : (level_q + W'(1));
                state_d = RELEASE;
            end
            REFUSE: begin
                state_d = RELEASE;
            end
            CLEAR: begin
                level_d = '0;
                state_d = IDLE;
            end
            RELEASE: begin
                if (!served_req_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ct      = ct_q;
    assign cn      = cn_q;
    assign ctr_rst = ctr_rst_q;
    assign up_ack  = up_ack_q;
    assign up_nak  = up_nak_q;
    assign dn_ack  = dn_ack_q;
    assign dn_nak  = dn_nak_q;
    assign level   = level_q;
    assign full    = (level_q == MAX_LVL);
    assign empty   = (level_q == '0);

endmodule

// File: tb/tb_ctr_step_sched.sv
// Directed bench for ctr_step_sched: a per-cycle vector table followed by
// handshake sequences for fill, contention, clear priority and async reset.
module tb_ctr_step_sched;

    logic       clk;
    logic       rst;
    logic       up_req, dn_req, clr;
    logic       up_ack, up_nak, dn_ack, dn_nak;
    logic       ct, cn, ctr_rst;
    logic [4:0] level;
    logic       full, empty;

    int n_chk;
    int n_fail;

    ctr_step_sched #(.MAXV(20), .W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .up_req  (up_req),
        .up_ack  (up_ack),
        .up_nak  (up_nak),
        .dn_req  (dn_req),
        .dn_ack  (dn_ack),
        .dn_nak  (dn_nak),
        .clr     (clr),
        .ct      (ct),
        .cn      (cn),
        .ctr_rst (ctr_rst),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {up_ack, up_nak, dn_ack, dn_nak, cn, ct, ctr_rst}
    typedef struct {
        logic       up;
        logic       dn;
        logic       cl;
        logic [6:0] flags;
        logic [4:0] lvl;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full request handshake on one side, checking the response and the new level
    task automatic hs(input logic side_dn, input logic exp_ok, input logic [4:0] exp_lvl);
        logic got;
        logic [6:0] seen;
        got  = 1'b0;
        seen = '0;
        if (side_dn) dn_req = 1'b1; else up_req = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc();
            if (up_ack || up_nak || dn_ack || dn_nak) begin
                got  = 1'b1;
                seen = {up_ack, up_nak, dn_ack, dn_nak, cn, ct, ctr_rst};
            end
        end
        chk("hs_response_seen", 32'(got), 32'd1);
        if (got) begin
            chk($sformatf("hs_flags dn=%0d lvl=%0d", side_dn, exp_lvl), 32'(seen),
                32'({~side_dn & exp_ok, ~side_dn & ~exp_ok, side_dn & exp_ok,
                     side_dn & ~exp_ok, exp_ok, side_dn & exp_ok, 1'b1}));
        end
        cyc();
        if (side_dn) dn_req = 1'b0; else up_req = 1'b0;
        cyc();
        chk($sformatf("hs_level dn=%0d", side_dn), 32'(level), 32'(exp_lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       want_dn;
        logic       got;
        logic [4:0] exp_lvl;

        n_chk  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 7'b0001001, 5'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 7'b0000001, 5'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 7'b0000001, 5'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 7'b1000101, 5'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 7'b0000001, 5'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 7'b0000001, 5'd1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 7'b0010111, 5'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 7'b0000001, 5'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 7'b0000001, 5'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 7'b1000101, 5'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 7'b0000001, 5'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 7'b0000001, 5'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 5'd1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 7'b0000001, 5'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 7'b1000101, 5'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 7'b0000001, 5'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 7'b0000001, 5'd1};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 7'b0000000, 5'd1};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 7'b0000001, 5'd0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 7'b1000101, 5'd0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 7'b0000001, 5'd1};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 7'b0000001, 5'd1};

        rst    = 1'b0;
        up_req = 1'b0;
        dn_req = 1'b0;
        clr    = 1'b0;
        #12;
        chk("reset_flags", 32'({up_ack, up_nak, dn_ack, dn_nak, cn, ct, ctr_rst}), 32'b0000001);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_full_empty", 32'({full, empty}), 32'b01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc();

        for (int i = 0; i < 22; i++) begin
            up_req = vecs[i].up;
            dn_req = vecs[i].dn;
            clr    = vecs[i].cl;
            cyc();
            chk($sformatf("vec%0d_flags", i),
                32'({up_ack, up_nak, dn_ack, dn_nak, cn, ct, ctr_rst}), 32'(vecs[i].flags));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_full_empty", i), 32'({full, empty}),
                32'({vecs[i].lvl == 5'd20, vecs[i].lvl == 5'd0}));
        end
        up_req = 1'b0;
        dn_req = 1'b0;
        clr    = 1'b0;
        cyc();

        // Reach level 5 with the decrement side served last, so up wins the next tie
        for (int k = 2; k <= 6; k++) hs(1'b0, 1'b1, 5'(k));
        hs(1'b1, 1'b1, 5'd5);

        // Contention: both held, each side drops for one cycle after its grant
        up_req  = 1'b1;
        dn_req  = 1'b1;
        want_dn = 1'b0;
        exp_lvl = 5'd5;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                cyc();
                if (up_ack || dn_ack || up_nak || dn_nak) got = 1'b1;
            end
            chk($sformatf("cont%0d_seen", g), 32'(got), 32'd1);
            chk($sformatf("cont%0d_side", g), 32'({up_ack, dn_ack}), 32'({~want_dn, want_dn}));
            exp_lvl = want_dn ? exp_lvl - 5'd1 : exp_lvl + 5'd1;
            cyc();
            if (want_dn) dn_req = 1'b0; else up_req = 1'b0;
            cyc();
            chk($sformatf("cont%0d_level", g), 32'(level), 32'(exp_lvl));
            if (g == 3) begin
                up_req = 1'b0;
                dn_req = 1'b0;
            end else if (want_dn) begin
                dn_req = 1'b1;
            end else begin
                up_req = 1'b1;
            end
            want_dn = ~want_dn;
        end
        cyc();
        chk("cont_final_level", 32'(level), 32'd5);

        // Clear priority at level 7
        hs(1'b0, 1'b1, 5'd6);
        hs(1'b0, 1'b1, 5'd7);
        clr    = 1'b1;
        up_req = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clrpri_clear", 32'({ctr_rst, up_ack, cn}), 32'b000);
        cyc();
        chk("clrpri_level0", 32'({level, ctr_rst, up_ack}), 32'({5'd0, 1'b1, 1'b0}));
        cyc();
        chk("clrpri_ack", 32'({up_ack, cn, ct}), 32'b110);
        cyc();
        up_req = 1'b0;
        chk("clrpri_level1", 32'(level), 32'd1);
        cyc();

        // Fill to full, then refusal at the top
        for (int k = 2; k <= 20; k++) hs(1'b0, 1'b1, 5'(k));
        chk("fill_full", 32'({full, empty}), 32'b10);
        hs(1'b0, 1'b0, 5'd20);
        chk("fill_full_after_nak", 32'(full), 32'd1);

        // Async reset in the middle of a decrement step
        dn_req = 1'b1;
        cyc();
        chk("arst_issue", 32'({dn_ack, cn, ct}), 32'b111);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_immediate", 32'({dn_ack, cn, ctr_rst, level}), 32'({1'b0, 1'b0, 1'b1, 5'd0}));
        dn_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc();
        chk("arst_post_level", 32'(level), 32'd0);
        hs(1'b0, 1'b1, 5'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
